uart_rx_param: RTL and testbench

Parametrised successor to the team's fixed 9600-8N1 serial receiver. It samples an asynchronous rx line with a configurable oversampling rate and takes a 3-sample majority vote at mid-bit. It supports configurable data width, parity mode and stop-bit count, and reports parity and framing errors alongside each received word. It sits between the board rx pin and the game-control logic and runs entirely in the system clock domain; no derived clocks are used.

---
 rtl/uart_rx_param.sv | 174 +++++++++++++++++
 tb/tb_uart_rx_param.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled UART receiver, majority vote at mid-bit.
// Ports: clk, reset (async, active-low), rx (serial in, idle high);
//   data_out (last word), data_valid (1-clk pulse per frame),
//   parity_err, frame_err (status of last frame), busy (frame in flight).
module uart_rx_param #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int DIV_RAW = (CLK_HZ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW      = $clog2(OVERSAMPLE);
    localparam int BW      = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int M       = OVERSAMPLE / 2;

    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [SW-1:0] S_LO    = SW'(M - 1);
    localparam logic [SW-1:0] S_MID   = SW'(M);
    localparam logic [SW-1:0] S_HI    = SW'(M + 1);
    localparam logic [SW-1:0] S_END   = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST  = BW'(DATA_BITS - 1);
    localparam logic          P_LAST  = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t                 r_state;
    logic                   r_rx_m;
    logic                   r_rx_s;
    logic [CW-1:0]          r_div;
    logic [SW-1:0]          r_s_cnt;
    logic [BW-1:0]          r_bit_cnt;
    logic                   r_stop_cnt;
    logic                   r_v0;
    logic                   r_v1;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_perr;
    logic                   r_ferr;

    logic w_tick;
    logic w_dec;
    logic w_end;
    logic w_maj;
    logic w_p;
    logic w_perr;

    assign w_tick = (r_div == DIV_M1);
    assign w_dec  = (r_s_cnt == S_HI);
    assign w_end  = (r_s_cnt == S_END);
    // Third sample is the live synchronised line at the decision tick.
    assign w_maj  = (r_v0 & r_v1) | (r_v0 & r_rx_s) | (r_v1 & r_rx_s);
    assign w_p    = (^r_shift) ^ w_maj;
    assign w_perr = (PARITY == 2) ? w_p : ~w_p;

    // Synchroniser idles high so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_m <= 1'b1;
            r_rx_s <= 1'b1;
        end else begin
            r_rx_m <= rx;
            r_rx_s <= r_rx_m;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_s_cnt    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_v0       <= 1'b1;
            r_v1       <= 1'b1;
            r_shift    <= '0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (r_state == S_IDLE) begin
                if (!r_rx_s) begin
                    r_state    <= S_START;
                    r_s_cnt    <= '0;
                    r_bit_cnt  <= '0;
                    r_stop_cnt <= 1'b0;
                    r_perr     <= 1'b0;
                    r_ferr     <= 1'b0;
                    busy       <= 1'b1;
                end
            end else if (w_tick) begin
                if (r_s_cnt == S_LO) r_v0 <= r_rx_s;
                if (r_s_cnt == S_MID) r_v1 <= r_rx_s;
                r_s_cnt <= w_end ? '0 : r_s_cnt + SW'(1);
                case (r_state)
                    S_START: begin
                        if (w_dec && w_maj) begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                        end else if (w_end) begin
                            r_state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (w_dec) r_shift[r_bit_cnt] <= w_maj;
                        if (w_end) begin
                            if (r_bit_cnt == B_LAST) begin
                                r_bit_cnt <= '0;
                                r_state   <= (PARITY != 0) ? S_PAR : S_STOP;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + BW'(1);
                            end
                        end
                    end
                    S_PAR: begin
                        if (w_dec) r_perr <= w_perr;
                        if (w_end) r_state <= S_STOP;
                    end
                    S_STOP: begin
                        // Finish at mid final stop bit to allow back-to-back frames.
                        if (w_dec) begin
                            if (r_stop_cnt == P_LAST) begin
                                data_out   <= r_shift;
                                parity_err <= (PARITY != 0) && r_perr;
                                frame_err  <= r_ferr | ~w_maj;
                                data_valid <= 1'b1;
                                busy       <= 1'b0;
                                r_state    <= S_IDLE;
                            end else if (!w_maj) begin
                                r_ferr <= 1'b1;
                            end
                        end else if (w_end) begin
                            r_stop_cnt <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three instances (8N1, 8E1, 8N2)
// at one tick per clk, 16 clks per bit.
module tb_uart_rx_param;

    logic       clk;
    logic       rst_n;
    logic [2:0] rxv;
    logic [7:0] dout [3];
    logic [2:0] dv;
    logic [2:0] pe;
    logic [2:0] fe;
    logic [2:0] bsy;

    int n_chk;
    int n_fail;
    int npulse [3];
    bit busy_seen [3];
    logic [7:0] hist [3][8];
    bit hpe [3][8];
    bit hfe [3][8];

    uart_rx_param #(.CLK_HZ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16),
                    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n1 (
        .clk(clk), .reset(rst_n), .rx(rxv[0]), .data_out(dout[0]),
        .data_valid(dv[0]), .parity_err(pe[0]), .frame_err(fe[0]), .busy(bsy[0]));

    uart_rx_param #(.CLK_HZ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16),
                    .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_e1 (
        .clk(clk), .reset(rst_n), .rx(rxv[1]), .data_out(dout[1]),
        .data_valid(dv[1]), .parity_err(pe[1]), .frame_err(fe[1]), .busy(bsy[1]));

    uart_rx_param #(.CLK_HZ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16),
                    .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_n2 (
        .clk(clk), .reset(rst_n), .rx(rxv[2]), .data_out(dout[2]),
        .data_valid(dv[2]), .parity_err(pe[2]), .frame_err(fe[2]), .busy(bsy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (dv[k]) begin
                hist[k][npulse[k] % 8] = dout[k];
                hpe[k][npulse[k] % 8]  = pe[k];
                hfe[k][npulse[k] % 8]  = fe[k];
                npulse[k] = npulse[k] + 1;
            end
            if (bsy[k]) busy_seen[k] = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tx_bit(input int sel, input logic b, input int glitch_at);
        for (int i = 0; i < 16; i++) begin
            rxv[sel] = (i == glitch_at) ? ~b : b;
            @(negedge clk);
        end
        rxv[sel] = 1'b1;
    endtask

    task automatic send(input int sel, input logic [7:0] d, input bit has_par,
                        input logic pbit, input int nstop, input logic stopv,
                        input int gbit);
        tx_bit(sel, 1'b0, -1);
        for (int i = 0; i < 8; i++) tx_bit(sel, d[i], (i == gbit) ? 9 : -1);
        if (has_par) tx_bit(sel, pbit, -1);
        for (int s = 0; s < nstop; s++) tx_bit(sel, stopv, -1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int n0;
    int n1;
    int n2;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        for (int k = 0; k < 3; k++) begin
            npulse[k]    = 0;
            busy_seen[k] = 1'b0;
        end
        rxv   = 3'b111;
        rst_n = 1'b0;
        idle(4);
        chk("rst_dout0", dout[0], 8'h00);
        chk("rst_flags0", {dv[0], pe[0], fe[0], bsy[0]}, 4'b0000);
        chk("rst_flags1", {dv[1], pe[1], fe[1], bsy[1]}, 4'b0000);
        chk("rst_flags2", {dv[2], pe[2], fe[2], bsy[2]}, 4'b0000);
        rst_n = 1'b1;
        idle(20);
        chk("rst_release_nopulse", npulse[0] + npulse[1] + npulse[2], 0);

        // 1: 8N1 0xA5
        n0 = npulse[0];
        send(0, 8'hA5, 1'b0, 1'b0, 1, 1'b1, -1);
        idle(4);
        chk("t1_pulses", npulse[0] - n0, 1);
        chk("t1_data", dout[0], 8'hA5);
        chk("t1_perr", pe[0], 1'b0);
        chk("t1_ferr", fe[0], 1'b0);
        chk("t1_busy", bsy[0], 1'b0);

        // 2: 4-clk glitch is rejected as a false start
        n0 = npulse[0];
        busy_seen[0] = 1'b0;
        rxv[0] = 1'b0;
        idle(4);
        rxv[0] = 1'b1;
        idle(16);
        chk("t2_busy_pulsed", busy_seen[0], 1'b1);
        chk("t2_busy_low", bsy[0], 1'b0);
        idle(20);
        chk("t2_nopulse", npulse[0] - n0, 0);
        chk("t2_data_held", dout[0], 8'hA5);

        // 3: 8E1 0x37, correct then wrong parity bit
        n1 = npulse[1];
        send(1, 8'h37, 1'b1, 1'b1, 1, 1'b1, -1);
        idle(4);
        chk("t3a_pulses", npulse[1] - n1, 1);
        chk("t3a_data", dout[1], 8'h37);
        chk("t3a_perr", pe[1], 1'b0);
        send(1, 8'h37, 1'b1, 1'b0, 1, 1'b1, -1);
        idle(4);
        chk("t3b_pulses", npulse[1] - n1, 2);
        chk("t3b_data", dout[1], 8'h37);
        chk("t3b_perr", pe[1], 1'b1);
        chk("t3b_ferr", fe[1], 1'b0);

        // 4: break (stop low), then good frame
        n0 = npulse[0];
        send(0, 8'h00, 1'b0, 1'b0, 1, 1'b0, -1);
        idle(40);
        chk("t4a_pulses", npulse[0] - n0, 1);
        chk("t4a_data", dout[0], 8'h00);
        chk("t4a_ferr", fe[0], 1'b1);
        send(0, 8'h12, 1'b0, 1'b0, 1, 1'b1, -1);
        idle(4);
        chk("t4b_pulses", npulse[0] - n0, 2);
        chk("t4b_data", dout[0], 8'h12);
        chk("t4b_ferr", fe[0], 1'b0);

        // 5: back-to-back frames with a mid-bit glitch on data bit 2
        n0 = npulse[0];
        send(0, 8'h55, 1'b0, 1'b0, 1, 1'b1, 2);
        send(0, 8'hAA, 1'b0, 1'b0, 1, 1'b1, -1);
        idle(4);
        chk("t5_n1_pulses", npulse[0] - n0, 2);
        chk("t5_n1_first", hist[0][n0 % 8], 8'h55);
        chk("t5_n1_second", hist[0][(n0 + 1) % 8], 8'hAA);
        chk("t5_n1_err", {hfe[0][n0 % 8], hfe[0][(n0 + 1) % 8]}, 2'b00);
        n2 = npulse[2];
        send(2, 8'h55, 1'b0, 1'b0, 2, 1'b1, -1);
        send(2, 8'hAA, 1'b0, 1'b0, 2, 1'b1, 2);
        idle(4);
        chk("t5_n2_pulses", npulse[2] - n2, 2);
        chk("t5_n2_first", hist[2][n2 % 8], 8'h55);
        chk("t5_n2_second", hist[2][(n2 + 1) % 8], 8'hAA);
        chk("t5_n2_err", {hfe[2][n2 % 8], hpe[2][n2 % 8],
                          hfe[2][(n2 + 1) % 8], hpe[2][(n2 + 1) % 8]}, 4'b0000);

        // 6: reset during data bit 3 of 0xFF
        n0 = npulse[0];
        tx_bit(0, 1'b0, -1);
        for (int i = 0; i < 3; i++) tx_bit(0, 1'b1, -1);
        idle(8);
        chk("t6_busy_mid", bsy[0], 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_dout", dout[0], 8'h00);
        chk("t6_rst_flags", {dv[0], pe[0], fe[0], bsy[0]}, 4'b0000);
        idle(3);
        rst_n = 1'b1;
        idle(40);
        chk("t6_nopulse", npulse[0] - n0, 0);
        send(0, 8'h3C, 1'b0, 1'b0, 1, 1'b1, -1);
        idle(4);
        chk("t6_pulses", npulse[0] - n0, 1);
        chk("t6_data", dout[0], 8'h3C);
        chk("t6_flags", {pe[0], fe[0], bsy[0]}, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
